// File: rtl/fifo_axis_tx.sv
// fifo_axis_tx: drains a first-word-fall-through FIFO into a registered AXI4-Stream master framed into i_pkt_len-beat packets.
// Define FIFO_AXIS_TX_STATS_EN to add accepted-beat and accepted-packet counters.
module fifo_axis_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_enable,
    input  logic [LEN_W-1:0]      i_pkt_len,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  o_idle,
    output logic                  o_pkt_done
`ifdef FIFO_AXIS_TX_STATS_EN
    ,
    output logic [31:0]           o_beat_total,
    output logic [31:0]           o_pkt_total
`endif
);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t state, state_n;
    logic [LEN_W-1:0] len_q, len_n, len_sel, beat_cnt, cnt_n;
    logic slot_free, last;
    // In IDLE beat_cnt is always 0, so the live length decides whether the first beat is also the last.
    always_comb begin
        slot_free = !m_axis_tvalid || m_axis_tready;
        o_fifo_rd = slot_free && !i_fifo_empty && (state == STREAM || i_enable) && !reset;
        len_sel   = (state == IDLE) ? ((i_pkt_len == '0) ? LEN_W'(1) : i_pkt_len) : len_q;
        last      = beat_cnt == len_sel - LEN_W'(1);
        len_n     = o_fifo_rd ? len_sel : len_q;
        cnt_n     = o_fifo_rd ? (last ? '0 : beat_cnt + LEN_W'(1)) : beat_cnt;
        state_n   = o_fifo_rd ? (last ? IDLE : STREAM) : state;
        o_idle    = state == IDLE && !m_axis_tvalid;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            len_q         <= '0;
            beat_cnt      <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            o_pkt_done    <= 1'b0;
        end else begin
            state      <= state_n;
            len_q      <= len_n;
            beat_cnt   <= cnt_n;
            o_pkt_done <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
            if (o_fifo_rd) begin
                m_axis_tdata  <= i_fifo_data;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= last;
            end else if (slot_free) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end
`ifdef FIFO_AXIS_TX_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            o_beat_total <= '0;
            o_pkt_total  <= '0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            o_beat_total <= o_beat_total + 32'd1;
            o_pkt_total  <= o_pkt_total + {31'd0, m_axis_tlast};
        end
    end
`endif
endmodule

// File: tb/tb_fifo_axis_tx.sv
// tb_fifo_axis_tx: directed vector table for fifo_axis_tx; each vector drives one cycle and checks pop plus registered outputs.
module tb_fifo_axis_tx;
    logic clk = 1'b0;
    logic reset, i_enable, i_fifo_empty, o_fifo_rd, m_axis_tvalid, m_axis_tlast, m_axis_tready, o_idle, o_pkt_done;
    logic [15:0] i_pkt_len;
    logic [31:0] i_fifo_data, m_axis_tdata;
`ifdef FIFO_AXIS_TX_STATS_EN
    logic [31:0] o_beat_total, o_pkt_total;
`endif
    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    fifo_axis_tx dut (
        .clk(clk), .reset(reset), .i_enable(i_enable), .i_pkt_len(i_pkt_len),
        .i_fifo_data(i_fifo_data), .i_fifo_empty(i_fifo_empty), .o_fifo_rd(o_fifo_rd),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready), .o_idle(o_idle), .o_pkt_done(o_pkt_done)
`ifdef FIFO_AXIS_TX_STATS_EN
        , .o_beat_total(o_beat_total), .o_pkt_total(o_pkt_total)
`endif
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] len;
        logic        empty;
        logic [31:0] data;
        logic        ready;
        logic        x_rd;
        logic        x_valid;
        logic [31:0] x_data;
        logic        x_last;
        logic        x_idle;
        logic        x_done;
    } vec_t;

    function automatic vec_t mk(logic r, logic e, logic [15:0] l, logic em, logic [31:0] d, logic rdy,
                                logic xr, logic xv, logic [31:0] xd, logic xl, logic xi, logic xdn);
        vec_t v;
        v.rst = r; v.en = e; v.len = l; v.empty = em; v.data = d; v.ready = rdy;
        v.x_rd = xr; v.x_valid = xv; v.x_data = xd; v.x_last = xl; v.x_idle = xi; v.x_done = xdn;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    endtask

    // Inputs change 1ns after the edge; the pop strobe is checked before the next edge, registered outputs 1ns after it.
    task automatic apply(input vec_t v, input int idx);
        reset = v.rst; i_enable = v.en; i_pkt_len = v.len;
        i_fifo_empty = v.empty; i_fifo_data = v.data; m_axis_tready = v.ready;
        #1;
        chk("fifo_rd", idx, {31'd0, o_fifo_rd}, {31'd0, v.x_rd});
        @(posedge clk);
        #1;
        chk("tvalid", idx, {31'd0, m_axis_tvalid}, {31'd0, v.x_valid});
        if (v.x_valid || v.rst) begin
            chk("tdata", idx, m_axis_tdata, v.x_data);
            chk("tlast", idx, {31'd0, m_axis_tlast}, {31'd0, v.x_last});
        end
        chk("idle", idx, {31'd0, o_idle}, {31'd0, v.x_idle});
        chk("pkt_done", idx, {31'd0, o_pkt_done}, {31'd0, v.x_done});
    endtask

    vec_t tbl[$];
    vec_t rs[$];

    initial begin
        // reset, then basic 4-beat packet
        tbl.push_back(mk(1,1,4,0,'h99,1, 0,0,'h0,0,1,0));
        tbl.push_back(mk(1,1,4,0,'h99,1, 0,0,'h0,0,1,0));
        tbl.push_back(mk(0,1,4,0,'h10,1, 1,1,'h10,0,0,0));
        tbl.push_back(mk(0,1,4,0,'h11,1, 1,1,'h11,0,0,0));
        tbl.push_back(mk(0,1,4,0,'h12,1, 1,1,'h12,0,0,0));
        tbl.push_back(mk(0,1,4,0,'h13,1, 1,1,'h13,1,0,0));
        tbl.push_back(mk(0,1,4,1,'h0,1, 0,0,'h0,0,1,1));
        tbl.push_back(mk(0,1,4,1,'h0,1, 0,0,'h0,0,1,0));
        // backpressure: tready low 5 cycles while A0 is held
        tbl.push_back(mk(0,1,3,0,'hA0,0, 1,1,'hA0,0,0,0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0,1,3,0,'hA1,0, 0,1,'hA0,0,0,0));
        tbl.push_back(mk(0,1,3,0,'hA1,1, 1,1,'hA1,0,0,0));
        tbl.push_back(mk(0,1,3,0,'hA2,1, 1,1,'hA2,1,0,0));
        tbl.push_back(mk(0,1,3,1,'h0,1, 0,0,'h0,0,1,1));
        // length 0 behaves as 1, then enable low in IDLE blocks pops
        tbl.push_back(mk(0,1,0,0,'h55,1, 1,1,'h55,1,0,0));
        tbl.push_back(mk(0,1,0,0,'h56,1, 1,1,'h56,1,0,1));
        tbl.push_back(mk(0,1,0,1,'h0,1, 0,0,'h0,0,1,1));
        tbl.push_back(mk(0,0,4,0,'h77,1, 0,0,'h0,0,1,0));
        // length 2, back-to-back packets with a 2-cycle empty gap mid-packet
        tbl.push_back(mk(0,1,2,0,'hB0,1, 1,1,'hB0,0,0,0));
        tbl.push_back(mk(0,1,2,0,'hB1,1, 1,1,'hB1,1,0,0));
        tbl.push_back(mk(0,1,2,0,'hB2,1, 1,1,'hB2,0,0,1));
        tbl.push_back(mk(0,1,2,1,'h0,1, 0,0,'h0,0,0,0));
        tbl.push_back(mk(0,1,2,1,'h0,1, 0,0,'h0,0,0,0));
        tbl.push_back(mk(0,1,2,0,'hB3,1, 1,1,'hB3,1,0,0));
        tbl.push_back(mk(0,1,2,0,'hB4,1, 1,1,'hB4,0,0,1));
        tbl.push_back(mk(0,1,2,0,'hB5,1, 1,1,'hB5,1,0,0));
        tbl.push_back(mk(0,1,2,1,'h0,1, 0,0,'h0,0,1,1));
        // enable dropped after beat 1 of 4; length change mid-packet ignored
        tbl.push_back(mk(0,1,4,0,'hC0,1, 1,1,'hC0,0,0,0));
        tbl.push_back(mk(0,0,4,0,'hC1,1, 1,1,'hC1,0,0,0));
        tbl.push_back(mk(0,0,9,0,'hC2,1, 1,1,'hC2,0,0,0));
        tbl.push_back(mk(0,0,9,0,'hC3,1, 1,1,'hC3,1,0,0));
        tbl.push_back(mk(0,0,4,0,'hC4,1, 0,0,'h0,0,1,1));
        tbl.push_back(mk(0,0,4,0,'hC4,1, 0,0,'h0,0,1,0));
        // reset after beat 2 of 5, then a full 5-beat packet restarts at beat 1
        rs.push_back(mk(0,1,5,0,'hD0,1, 1,1,'hD0,0,0,0));
        rs.push_back(mk(0,1,5,0,'hD1,1, 1,1,'hD1,0,0,0));
        rs.push_back(mk(1,1,5,0,'hD2,1, 0,0,'h0,0,1,0));
        rs.push_back(mk(0,1,5,0,'hE0,1, 1,1,'hE0,0,0,0));
        rs.push_back(mk(0,1,5,0,'hE1,1, 1,1,'hE1,0,0,0));
        rs.push_back(mk(0,1,5,0,'hE2,1, 1,1,'hE2,0,0,0));
        rs.push_back(mk(0,1,5,0,'hE3,1, 1,1,'hE3,0,0,0));
        rs.push_back(mk(0,1,5,0,'hE4,1, 1,1,'hE4,1,0,0));
        rs.push_back(mk(0,1,5,1,'h0,1, 0,0,'h0,0,1,1));

        reset = 1'b1; i_enable = 1'b0; i_pkt_len = '0; i_fifo_empty = 1'b1; i_fifo_data = '0; m_axis_tready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
        for (int i = 0; i < rs.size(); i++) apply(rs[i], 100 + i);
`ifdef FIFO_AXIS_TX_STATS_EN
        apply(mk(1,1,4,1,'h0,1, 0,0,'h0,0,1,0), 200);
        chk("beat_total_rst", 200, o_beat_total, 32'd0);
        chk("pkt_total_rst", 200, o_pkt_total, 32'd0);
        for (int i = 0; i < 12; i++)
            apply(mk(0,1,4,0,32'h100 + i,1, 1,1,32'h100 + i,(i % 4) == 3,0,(i % 4) == 0 && i > 0), 201 + i);
        apply(mk(0,1,4,1,'h0,1, 0,0,'h0,0,1,1), 213);
        chk("beat_total", 213, o_beat_total, 32'd12);
        chk("pkt_total", 213, o_pkt_total, 32'd3);
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/fifo_axis_tx.md
Name: fifo_axis_tx

Overview:
- Read-side drainer for the team's synchronous FIFO (first-word fall-through: data is valid whenever the FIFO is not empty).
- Pops words and presents them as a registered AXI4-Stream master.
- Frames the stream into packets of a programmable beat count and asserts TLAST on the final beat of each packet.
- Sits between the result FIFO and the stream output / DMA S2MM port.

Parameters:
- DATA_WIDTH, 32, width of FIFO words and TDATA.
- LEN_W, 16, width of the packet-length input and the beat counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_enable  in  1  permit starting new packets
- i_pkt_len  in  LEN_W  beats per packet; sampled at packet start; 0 treated as 1
- i_fifo_data  in  DATA_WIDTH  FIFO head word (valid when !i_fifo_empty)
- i_fifo_empty  in  1  FIFO empty flag
- o_fifo_rd  out  1  pop strobe (combinational)
- m_axis_tdata  out  DATA_WIDTH  stream data (registered)
- m_axis_tvalid  out  1  stream valid (registered)
- m_axis_tlast  out  1  last beat of packet (registered)
- m_axis_tready  in  1  downstream ready
- o_idle  out  1  IDLE state and no beat pending
- o_pkt_done  out  1  one-cycle pulse when a TLAST beat is accepted

Behaviour:
- Reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, beat counter=0, state=IDLE, o_pkt_done=0. Reset wins over all other events in the same cycle; reset mid-packet drops the held beat and the partial packet. The FIFO is not popped during reset.
- Output register is free when `slot_free = !m_axis_tvalid || m_axis_tready`.
- `o_fifo_rd = slot_free && !i_fifo_empty && (state==STREAM || (state==IDLE && i_enable)) && !reset`.
- Never pop when i_fifo_empty=1; there is no underflow.
- On a pop:
  - tdata <= i_fifo_data
  - tvalid <= 1
  - tlast <= (beat_cnt == len_q-1)
- If slot_free and no pop, then tvalid <= 0.
- Once tvalid=1, tdata and tlast are held stable until accepted (AXI rule: valid never retracts without ready).
- Latency: FIFO non-empty at cycle N gives tvalid at N+1. Sustained throughput is 1 beat/cycle with tready=1 and the FIFO non-empty.
- State machine:
  - IDLE: on a pop, len_q <= max(i_pkt_len,1), beat_cnt <= 1, and go to STREAM. If len_q==1, the beat carries tlast and the state stays IDLE.
  - STREAM: each pop increments beat_cnt. The pop with beat_cnt == len_q-1 sets tlast, clears beat_cnt to 0, and returns to IDLE.
- i_enable is checked only in IDLE. Deasserting it mid-packet does not truncate the packet: the current packet completes, then no new packet starts.
- i_pkt_len changes mid-packet are ignored (len_q is latched).
- Back-to-back packets: the IDLE to STREAM transition costs no bubble, because a pop can happen in the same cycle as returning to IDLE.
- Max length 2^LEN_W-1 beats; beat_cnt never wraps within a packet.
- o_pkt_done = registered (tvalid && tready && tlast).
- o_idle = (state==IDLE) && !m_axis_tvalid.

Optional Feature:
- Macro: FIFO_AXIS_TX_STATS_EN.
- When defined, adds two outputs:
  - o_beat_total (32 bits): increments on every accepted beat (tvalid && tready).
  - o_pkt_total (32 bits): increments on every accepted tlast beat.
- Both counters clear on reset and wrap modulo 2^32.
- When not defined, these ports and their logic are absent and the rest of the block is identical.

Test Plan:
- Basic packet: reset, i_pkt_len=4, i_enable=1, FIFO preloaded with 0x10..0x13, tready=1 -> four beats on consecutive cycles, first beat one cycle after the first pop, tlast only on 0x13, one o_pkt_done pulse, o_idle=1 afterwards.
- Backpressure: i_pkt_len=3, data 0xA0..0xA2, tready low for 5 cycles while tvalid=1 -> tdata stays 0xA0 and exactly one pop occurs until accepted; total of 3 pops; tlast on 0xA2.
- Bubbles and back-to-back: FIFO empty for 2 cycles mid-packet, i_pkt_len=2, 6 words -> tvalid drops during the gap with no spurious pop; three packets with tlast on beats 2, 4 and 6; no idle cycle between packets when data is present.
- Enable and length edge cases:
  - i_pkt_len=0 -> every beat has tlast=1.
  - i_enable dropped after beat 1 of 4 -> all 4 beats still complete, then no further pops.
- Reset mid-packet: reset asserted after beat 2 of 5 -> tvalid=0 and tlast=0 the next cycle; the next packet restarts at beat 1 with tlast on its 5th beat.
- Stats (FIFO_AXIS_TX_STATS_EN defined): 3 packets of 4 beats -> o_beat_total=12, o_pkt_total=3; both counters read 0 after reset.
